// File: rtl/rv_pkg.sv
// Shared RV32I constants and the load/store unit state type.
package rv_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } lsu_state_t;

  function automatic logic [2:0] funct3_of(input logic [31:0] instr);
    return instr[14:12];
  endfunction

endpackage

// File: rtl/lsu_mw_if.sv
// Data-memory req/ack bus between the load/store unit and the memory slave.
interface lsu_mw_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, we, addr, be, wdata, input ack, rdata);
  modport slave  (input req, we, addr, be, wdata, output ack, rdata);
endinterface

// File: rtl/lsu_mw_align.sv
// Combinational lane logic: misalignment detect, store steering, load extension.
module lsu_align
  import rv_pkg::*;
(
  input  logic [31:0] instr_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] rs2_i,
  input  logic [31:0] rdata_i,
  output logic        is_load_o,
  output logic        is_store_o,
  output logic        misalign_o,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_ext_o
);

  logic [2:0]  f3;
  logic [31:0] shifted;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  // Only opcode and funct3 select behaviour; the other fields are don't-care here.
  logic unused_instr;
  assign unused_instr = ^{instr_i[31:15], instr_i[11:7]};

  assign f3 = funct3_of(instr_i);

  // Decode opcode, flag misaligned halfword/word accesses, steer store data and extend load data.
  always_comb begin
    // NOTE: every output gets a default first so no path through the cases can infer a latch.
    is_load_o  = (instr_i[6:0] == OPC_LOAD);
    is_store_o = (instr_i[6:0] == OPC_STORE);
    misalign_o = 1'b0;
    be_o       = 4'b0000;
    wdata_o    = rs2_i;
    load_ext_o = rdata_i;
    shifted    = rdata_i >> {addr_i[1:0], 3'b000};
    lane_byte  = shifted[7:0];
    lane_half  = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    if (is_load_o || is_store_o) begin
      unique case (f3)
        F3_H, F3_HU: misalign_o = addr_i[0];
        F3_W:        misalign_o = (addr_i[1:0] != 2'b00);
        default:     misalign_o = 1'b0;
      endcase
    end

    // Loads never assert byte enables; only stores steer lanes.
    if (is_store_o) begin
      unique case (f3[1:0])
        2'b00: begin
          wdata_o = {4{rs2_i[7:0]}};
          be_o    = 4'b0001 << addr_i[1:0];
        end
        2'b01: begin
          wdata_o = {2{rs2_i[15:0]}};
          be_o    = 4'b0011 << addr_i[1:0];
        end
        default: begin
          wdata_o = rs2_i;
          be_o    = 4'b1111;
        end
      endcase
    end

    unique case (f3)
      F3_B:    load_ext_o = {{24{lane_byte[7]}}, lane_byte};
      F3_BU:   load_ext_o = {24'd0, lane_byte};
      F3_H:    load_ext_o = {{16{lane_half[15]}}, lane_half};
      F3_HU:   load_ext_o = {16'd0, lane_half};
      default: load_ext_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/lsu_mw.sv
// MW-stage load/store unit: drives the data bus, stalls the pipe until ack,
// and registers the extended load result for writeback.
module lsu_mw
  import rv_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_E,
  input  logic [31:0] alu_o_E,
  input  logic [31:0] rdata2_E,
  lsu_mw_if.master    dbus,
  output logic        stall_MW,
  output logic [31:0] load_data,
  output logic        misalign,
  output logic        bus_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  lsu_state_t  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [31:0] load_data_q, load_data_d;
  logic        bus_err_q, bus_err_d;

  logic        is_load, is_store, mem_op, req;
  logic [3:0]  be;
  logic [31:0] wdata, load_ext;

  lsu_align u_align (
    .instr_i    (instr_E),
    .addr_i     (alu_o_E),
    .rs2_i      (rdata2_E),
    .rdata_i    (dbus.rdata),
    .is_load_o  (is_load),
    .is_store_o (is_store),
    .misalign_o (misalign),
    .be_o       (be),
    .wdata_o    (wdata),
    .load_ext_o (load_ext)
  );

  assign mem_op  = (is_load || is_store) && !misalign;
  assign cnt_inc = cnt_q + 1'b1;

  // Next-state, counter and load-result logic for the IDLE/WAIT/DONE handshake.
  always_comb begin
    state_d     = state_q;
    cnt_d       = '0;
    load_data_d = load_data_q;
    bus_err_d   = 1'b0;
    req         = 1'b0;
    stall_MW    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (mem_op) begin
          req      = 1'b1;
          stall_MW = 1'b1;
          if (dbus.ack) begin
            state_d = DONE;
            if (is_load) load_data_d = load_ext;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        req      = 1'b1;
        stall_MW = mem_op;
        cnt_d    = cnt_inc;
        if (dbus.ack) begin
          state_d = DONE;
          if (is_load) load_data_d = load_ext;
        end else if (cnt_inc == CW'(TIMEOUT)) begin
          // Slave never answered: abort, flag it, and hand writeback a clean zero.
          state_d     = DONE;
          bus_err_d   = 1'b1;
          load_data_d = '0;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counter, load result and error pulse registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers sample the same pre-edge values.
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      load_data_q <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      load_data_q <= load_data_d;
      bus_err_q   <= bus_err_d;
    end
  end

  // A request seen while reset is high is withdrawn; the slave treats it as cancelled.
  assign dbus.req   = req && !reset;
  assign dbus.we    = is_store;
  assign dbus.addr  = {alu_o_E[31:2], 2'b00};
  assign dbus.be    = be;
  assign dbus.wdata = wdata;

  assign load_data = load_data_q;
  assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_lsu_mw.sv
// Self-checking bench for lsu_mw: a vector table for single-cycle accesses plus
// hand-written sequences for wait states, timeout and reset during an access.
module tb_lsu_mw;

  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] addr;
    logic [31:0] rs2;
    logic [31:0] rdata;
    logic        exp_mis;
    logic        exp_req;
    logic        exp_we;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic        cap;
    logic [31:0] exp_ld;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr_E, alu_o_E, rdata2_E;
  logic        stall_MW, misalign, bus_err;
  logic [31:0] load_data;

  int checks = 0;
  int errors = 0;

  lsu_mw_if dbus ();

  lsu_mw #(.TIMEOUT(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .instr_E   (instr_E),
    .alu_o_E   (alu_o_E),
    .rdata2_E  (rdata2_E),
    .dbus      (dbus),
    .stall_MW  (stall_MW),
    .load_data (load_data),
    .misalign  (misalign),
    .bus_err   (bus_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [6:0] opc, input logic [2:0] f3);
    return {17'd0, f3, 5'd1, opc};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t        vecs[16];
    logic [31:0] model_ld;
    int          n;

    vecs[0]  = '{mk(LD, 3'b000), 32'h103, 32'h0, 32'h80FF0000, 1'b0, 1'b1, 1'b0, 4'b0000, 32'h0, 1'b1, 32'hFFFFFF80};
    vecs[1]  = '{mk(LD, 3'b100), 32'h103, 32'h0, 32'h80FF0000, 1'b0, 1'b1, 1'b0, 4'b0000, 32'h0, 1'b1, 32'h00000080};
    vecs[2]  = '{mk(LD, 3'b001), 32'h102, 32'h0, 32'h80FF0000, 1'b0, 1'b1, 1'b0, 4'b0000, 32'h0, 1'b1, 32'hFFFF80FF};
    vecs[3]  = '{mk(LD, 3'b101), 32'h100, 32'h0, 32'h1234F00D, 1'b0, 1'b1, 1'b0, 4'b0000, 32'h0, 1'b1, 32'h0000F00D};
    vecs[4]  = '{mk(LD, 3'b010), 32'h200, 32'h0, 32'hCAFEBABE, 1'b0, 1'b1, 1'b0, 4'b0000, 32'h0, 1'b1, 32'hCAFEBABE};
    vecs[5]  = '{mk(LD, 3'b000), 32'h101, 32'h0, 32'h00007F00, 1'b0, 1'b1, 1'b0, 4'b0000, 32'h0, 1'b1, 32'h0000007F};
    vecs[6]  = '{mk(LD, 3'b101), 32'h102, 32'h0, 32'h80FF0000, 1'b0, 1'b1, 1'b0, 4'b0000, 32'h0, 1'b1, 32'h000080FF};
    vecs[7]  = '{mk(ST, 3'b001), 32'h102, 32'h1234ABCD, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b1, 4'b1100, 32'hABCDABCD, 1'b0, 32'h0};
    vecs[8]  = '{mk(ST, 3'b000), 32'h101, 32'h000000A5, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b1, 4'b0010, 32'hA5A5A5A5, 1'b0, 32'h0};
    vecs[9]  = '{mk(ST, 3'b010), 32'h104, 32'h11223344, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b1, 4'b1111, 32'h11223344, 1'b0, 32'h0};
    vecs[10] = '{mk(ST, 3'b000), 32'h103, 32'hFFFFFF5A, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b1, 4'b1000, 32'h5A5A5A5A, 1'b0, 32'h0};
    vecs[11] = '{mk(LD, 3'b010), 32'h101, 32'h0, 32'h11111111, 1'b1, 1'b0, 1'b0, 4'b0000, 32'h0, 1'b0, 32'h0};
    vecs[12] = '{mk(ST, 3'b001), 32'h103, 32'h5555, 32'h22222222, 1'b1, 1'b0, 1'b1, 4'b0000, 32'h0, 1'b0, 32'h0};
    vecs[13] = '{mk(LD, 3'b001), 32'h101, 32'h0, 32'h33333333, 1'b1, 1'b0, 1'b0, 4'b0000, 32'h0, 1'b0, 32'h0};
    vecs[14] = '{mk(ST, 3'b010), 32'h102, 32'h77, 32'h44444444, 1'b1, 1'b0, 1'b1, 4'b0000, 32'h0, 1'b0, 32'h0};
    vecs[15] = '{32'h00100093, 32'h104, 32'h0, 32'h55555555, 1'b0, 1'b0, 1'b0, 4'b0000, 32'h0, 1'b0, 32'h0};

    // Reset state with a bubble in the stage.
    reset = 1'b1;
    instr_E = 32'h0; alu_o_E = 32'h0; rdata2_E = 32'h0;
    dbus.ack = 1'b0; dbus.rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("rst_req", dbus.req, 0);
    check("rst_stall", stall_MW, 0);
    check("rst_misalign", misalign, 0);
    check("rst_load_data", load_data, 0);
    check("rst_bus_err", bus_err, 0);
    model_ld = 32'h0;

    // LW at 0x100 acked in the third request cycle.
    @(posedge clk); #1;
    instr_E = mk(LD, 3'b010); alu_o_E = 32'h100; dbus.rdata = 32'hDEADBEEF; dbus.ack = 1'b0;
    #1;
    check("lw_req", dbus.req, 1);
    check("lw_addr", dbus.addr, 32'h100);
    check("lw_be", dbus.be, 4'b0000);
    check("lw_we", dbus.we, 0);
    n = 0;
    while (stall_MW && n < 10) begin
      n++;
      if (n == 3) dbus.ack = 1'b1;
      @(posedge clk); #2;
    end
    check("lw_stall_cycles", n, 3);
    check("lw_done_req", dbus.req, 0);
    check("lw_done_load", load_data, 32'hDEADBEEF);
    dbus.ack = 1'b0; instr_E = 32'h0;
    @(posedge clk); #2;
    check("lw_hold_load", load_data, 32'hDEADBEEF);
    check("lw_idle_stall", stall_MW, 0);
    model_ld = 32'hDEADBEEF;

    // Single-cycle accesses with the slave acking immediately.
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      instr_E = vecs[i].instr; alu_o_E = vecs[i].addr; rdata2_E = vecs[i].rs2;
      dbus.rdata = vecs[i].rdata; dbus.ack = 1'b1;
      #1;
      check($sformatf("v%0d_misalign", i), misalign, vecs[i].exp_mis);
      check($sformatf("v%0d_req", i), dbus.req, vecs[i].exp_req);
      check($sformatf("v%0d_stall", i), stall_MW, vecs[i].exp_req);
      if (vecs[i].exp_req) begin
        check($sformatf("v%0d_addr", i), dbus.addr, {vecs[i].addr[31:2], 2'b00});
        check($sformatf("v%0d_we", i), dbus.we, vecs[i].exp_we);
        check($sformatf("v%0d_be", i), dbus.be, vecs[i].exp_be);
        if (vecs[i].exp_we)
          check($sformatf("v%0d_wdata", i), dbus.wdata, vecs[i].exp_wdata);
      end
      if (vecs[i].cap) model_ld = vecs[i].exp_ld;
      @(posedge clk); #2;
      check($sformatf("v%0d_load_data", i), load_data, model_ld);
      if (vecs[i].exp_req) begin
        check($sformatf("v%0d_done_stall", i), stall_MW, 0);
        check($sformatf("v%0d_done_req", i), dbus.req, 0);
      end
      instr_E = 32'h0; dbus.ack = 1'b0;
    end

    // Reset asserted while waiting for an ack.
    @(posedge clk); #1;
    instr_E = mk(LD, 3'b010); alu_o_E = 32'h400; dbus.ack = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check("rw_wait_req", dbus.req, 1);
    reset = 1'b1;
    #1;
    check("rw_req_gated", dbus.req, 0);
    @(posedge clk); #1;
    reset = 1'b0; instr_E = 32'h0;
    #1;
    check("rw_stall", stall_MW, 0);
    check("rw_load_data", load_data, 0);
    check("rw_bus_err", bus_err, 0);
    check("rw_req", dbus.req, 0);

    // Quick load so the timeout's zeroing of load_data is observable.
    @(posedge clk); #1;
    instr_E = mk(LD, 3'b010); alu_o_E = 32'h300; dbus.rdata = 32'h5A5A1234; dbus.ack = 1'b1;
    @(posedge clk); #2;
    check("pre_to_load", load_data, 32'h5A5A1234);
    instr_E = 32'h0; dbus.ack = 1'b0;

    // No ack ever: one request cycle plus four WAIT cycles, then DONE with bus_err.
    @(posedge clk); #1;
    instr_E = mk(LD, 3'b010); alu_o_E = 32'h10; dbus.rdata = 32'hFFFFFFFF; dbus.ack = 1'b0;
    #1;
    n = 0;
    while (stall_MW && n < 20) begin
      check($sformatf("to_err_early%0d", n), bus_err, 0);
      n++;
      @(posedge clk); #2;
    end
    check("to_stall_cycles", n, 5);
    check("to_bus_err", bus_err, 1);
    check("to_load_data", load_data, 0);
    check("to_done_req", dbus.req, 0);
    instr_E = 32'h0;
    @(posedge clk); #2;
    check("to_err_pulse", bus_err, 0);
    check("to_idle_stall", stall_MW, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
